// File: rtl/systolic_pkg.sv
// Shared types and helpers for the weight-stationary systolic matmul engine.
// Optional weight reuse is compiled in with SA_WEIGHT_REUSE_EN.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    COMPUTE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic last;
    logic vld;
  } tok_t;

  function automatic int sa_latency(input int rows, input int cols);
    return rows + cols;
  endfunction

  function automatic int sa_cw(input int max_m);
    return $clog2(max_m + 1);
  endfunction

endpackage

// File: rtl/pe.sv
// Weight-stationary processing element: holds one weight, forwards the
// activation right and adds its product into the partial sum flowing down.
module pe #(
  parameter int DW          = 8,
  parameter int WW          = 8,
  parameter int AW          = 32,
  parameter int SIGNED_MATH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          w_load,
  input  logic [WW-1:0] w_in,
  input  logic [DW-1:0] a_in,
  input  logic [AW-1:0] psum_in,
  output logic [DW-1:0] a_out,
  output logic [AW-1:0] psum_out
);

  logic [WW-1:0] w;
  logic [AW-1:0] ax;
  logic [AW-1:0] wx;

  // Extending both operands to AW makes the truncated product exact mod 2^AW.
  assign ax = {{(AW-DW){(SIGNED_MATH != 0) && a_in[DW-1]}}, a_in};
  assign wx = {{(AW-WW){(SIGNED_MATH != 0) && w[WW-1]}}, w};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w        <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      if (w_load) w <= w_in;
      if (en) begin
        a_out    <= a_in;
        psum_out <= psum_in + ax * wx;
      end
    end
  end

endmodule

// File: rtl/sa_delay_line.sv
// Stall-aware shift register; DEPTH=0 degenerates to a wire.
// Used for input skew, output deskew and the valid/last token line.
module sa_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = clk ^ rst_n ^ en;
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (en) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end
    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/systolic_matmul_engine.sv
// Self-sequenced ROWSxCOLS weight-stationary systolic engine, R = A x W.
// Define SA_WEIGHT_REUSE_EN to add reuse_w and skip reloading weights.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int SIGNED_MATH  = 1,
  parameter int MAX_M        = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [sa_cw(MAX_M)-1:0]         m_count,
`ifdef SA_WEIGHT_REUSE_EN
  input  logic                            reuse_w,
`endif
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [COLS*WEIGHT_WIDTH-1:0]    w_data,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]      a_data,
  output logic                            r_valid,
  input  logic                            r_ready,
  output logic [COLS*ACC_WIDTH-1:0]       r_data,
  output logic                            r_last,
  output logic                            busy,
  output logic                            done
);

  localparam int DW = DATA_WIDTH;
  localparam int WW = WEIGHT_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int CW = sa_cw(MAX_M);
  localparam int RW = $clog2(ROWS + 1);
  localparam int TOK_DEPTH = sa_latency(ROWS, COLS) - 1;
  localparam logic [CW-1:0] M_MAX = CW'(MAX_M);

  state_t        state;
  logic [CW-1:0] m;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [RW-1:0] w_cnt;
`ifdef SA_WEIGHT_REUSE_EN
  logic          weights_loaded;
`endif

  logic adv;
  logic a_fire;
  logic w_fire;

  assign adv     = !r_valid || r_ready;
  assign w_ready = (state == LOAD_W);
  assign a_ready = (state == COMPUTE) && adv && (in_cnt < m);
  assign busy    = (state != IDLE);
  assign w_fire  = w_valid && w_ready;
  assign a_fire  = a_valid && a_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m       <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      w_cnt   <= '0;
      done    <= 1'b0;
`ifdef SA_WEIGHT_REUSE_EN
      weights_loaded <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (a_fire) in_cnt <= in_cnt + 1'b1;
      if (r_valid && r_ready) out_cnt <= out_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            w_cnt   <= '0;
            if (m_count == '0) begin
              done <= 1'b1;
            end else begin
              m <= (m_count > M_MAX) ? M_MAX : m_count;
`ifdef SA_WEIGHT_REUSE_EN
              state <= (reuse_w && weights_loaded) ? COMPUTE : LOAD_W;
`else
              state <= LOAD_W;
`endif
            end
          end
        end
        LOAD_W: begin
          if (w_fire) begin
            w_cnt <= w_cnt + 1'b1;
            if (w_cnt == RW'(ROWS - 1)) begin
              state <= COMPUTE;
`ifdef SA_WEIGHT_REUSE_EN
              weights_loaded <= 1'b1;
`endif
            end
          end
        end
        COMPUTE: if (in_cnt == m) state <= DRAIN;
        DRAIN: begin
          if (out_cnt == m) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Input register: idle cycles inject zero bubbles with an invalid token.
  logic [ROWS*DW-1:0] a_reg;
  tok_t               a_tok;
  tok_t               tok_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      a_tok <= '0;
    end else if (adv) begin
      a_reg      <= a_fire ? a_data : '0;
      a_tok.vld  <= a_fire;
      a_tok.last <= a_fire && (in_cnt == m - 1'b1);
    end
  end

  sa_delay_line #(.DEPTH(TOK_DEPTH), .WIDTH(2)) u_tok (
    .clk, .rst_n, .en(adv), .d(a_tok), .q(tok_o)
  );

  logic [DW-1:0] act  [ROWS][COLS+1];
  logic [AW-1:0] psum [ROWS+1][COLS];
  logic [AW-1:0] desk [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic unused_tail;
    assign unused_tail = ^act[r][COLS];

    sa_delay_line #(.DEPTH(r), .WIDTH(DW)) u_skew (
      .clk, .rst_n, .en(adv),
      .d(a_reg[r*DW +: DW]), .q(act[r][0])
    );

    for (genvar c = 0; c < COLS; c++) begin : g_col
      pe #(.DW(DW), .WW(WW), .AW(AW), .SIGNED_MATH(SIGNED_MATH)) u_pe (
        .clk, .rst_n, .en(adv),
        .w_load(w_fire && (w_cnt == RW'(r))),
        .w_in(w_data[c*WW +: WW]),
        .a_in(act[r][c]),
        .psum_in(psum[r][c]),
        .a_out(act[r][c+1]),
        .psum_out(psum[r+1][c])
      );
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_desk
    assign psum[0][c] = '0;
    sa_delay_line #(.DEPTH(COLS - 1 - c), .WIDTH(AW)) u_desk (
      .clk, .rst_n, .en(adv),
      .d(psum[ROWS][c]), .q(desk[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (adv) begin
      r_valid <= tok_o.vld;
      r_last  <= tok_o.last;
      if (tok_o.vld) begin
        for (int c = 0; c < COLS; c++) r_data[c*AW +: AW] <= desk[c];
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Randomized bench for systolic_matmul_engine against a plain matmul model.
// Signed and unsigned instances run in lockstep on the same stimulus.
module tb_systolic_matmul_engine;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DW    = 8;
  localparam int WW    = 8;
  localparam int AW    = 32;
  localparam int MAX_M = 256;
  localparam int CW    = 9;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [CW-1:0]        m_count = '0;
  logic                 w_valid = 1'b0;
  logic [COLS*WW-1:0]   w_data = '0;
  logic                 a_valid = 1'b0;
  logic [ROWS*DW-1:0]   a_data = '0;
  logic                 r_ready = 1'b0;
`ifdef SA_WEIGHT_REUSE_EN
  logic                 reuse_w = 1'b0;
`endif

  logic w_ready, a_ready, r_valid, r_last, busy, done;
  logic [COLS*AW-1:0] r_data;
  logic w_ready_u, a_ready_u, r_valid_u, r_last_u, busy_u, done_u;
  logic [COLS*AW-1:0] r_data_u;

  systolic_matmul_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
    .ACC_WIDTH(AW), .SIGNED_MATH(1), .MAX_M(MAX_M)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m_count(m_count),
`ifdef SA_WEIGHT_REUSE_EN
    .reuse_w(reuse_w),
`endif
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_last(r_last), .busy(busy), .done(done)
  );

  systolic_matmul_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
    .ACC_WIDTH(AW), .SIGNED_MATH(0), .MAX_M(MAX_M)
  ) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .m_count(m_count),
`ifdef SA_WEIGHT_REUSE_EN
    .reuse_w(reuse_w),
`endif
    .w_valid(w_valid), .w_ready(w_ready_u), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready_u), .a_data(a_data),
    .r_valid(r_valid_u), .r_ready(r_ready), .r_data(r_data_u),
    .r_last(r_last_u), .busy(busy_u), .done(done_u)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int w_seen = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (w_ready) w_seen <= w_seen + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [WW-1:0]      W [ROWS][COLS];
  logic [ROWS*DW-1:0] avec [$];
  int hs0, rv0, rvl;
  logic [COLS*AW-1:0] last_rs, last_ru;

  function automatic logic [COLS*AW-1:0] ref_mm(input logic [ROWS*DW-1:0] a,
                                                input bit sgn);
    logic [COLS*AW-1:0] res;
    longint s, x, y;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      s = 0;
      for (int r = 0; r < ROWS; r++) begin
        x = longint'(a[r*DW +: DW]);
        y = longint'(W[r][c]);
        if (sgn && x >= (1 << (DW-1))) x -= (1 << DW);
        if (sgn && y >= (1 << (WW-1))) y -= (1 << WW);
        s += x * y;
      end
      res[c*AW +: AW] = s[AW-1:0];
    end
    return res;
  endfunction

  task automatic rand_w();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) W[r][c] = WW'($urandom);
  endtask

  task automatic rand_a(input int n);
    avec = {};
    for (int k = 0; k < n; k++) avec.push_back((ROWS*DW)'($urandom));
  endtask

  task automatic pulse_start(input int mc, input bit ru);
    start = 1'b1;
    m_count = CW'(mc);
`ifdef SA_WEIGHT_REUSE_EN
    reuse_w = ru;
`else
    if (ru) $display("note: reuse requested without reuse support");
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic produce(input int ms, input bit send_w);
    bit f;
    int t;
    if (send_w) begin
      for (int i = 0; i < ROWS; i++) begin
        w_valid = 1'b1;
        for (int c = 0; c < COLS; c++) w_data[c*WW +: WW] = W[i][c];
        t = 0;
        do begin
          @(negedge clk); f = w_ready;
          @(posedge clk); #1; t++;
        end while (!f && t < 200);
        if (!f) begin
          n_vec++; n_err++;
          $display("FAIL w_handshake: row %0d not accepted in %0d cycles", i, t);
        end
      end
    end
    w_valid = 1'b0;
    for (int k = 0; k < ms; k++) begin
      a_valid = 1'b1;
      a_data = avec[k];
      t = 0;
      do begin
        @(negedge clk); f = a_ready;
        @(posedge clk); #1; t++;
      end while (!f && t < 400);
      if (k == 0) hs0 = cyc;
      if (!f) begin
        n_vec++; n_err++;
        $display("FAIL a_handshake: vector %0d not accepted in %0d cycles", k, t);
        break;
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic consume(input int ms, input bit rnd);
    int got = 0;
    int t = 0;
    bit first = 1'b1;
    logic [COLS*AW-1:0] es, eu;
    while (got < ms && t < 3000) begin
      r_ready = rnd ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
      if (r_valid) begin
        if (first) begin rv0 = cyc; first = 1'b0; end
        es = ref_mm(avec[got], 1'b1);
        eu = ref_mm(avec[got], 1'b0);
        n_vec++;
        if (r_data !== es) begin
          n_err++;
          $display("FAIL r_data_signed[%0d]: got %h want %h", got, r_data, es);
        end
        n_vec++;
        if (r_data_u !== eu) begin
          n_err++;
          $display("FAIL r_data_unsigned[%0d]: got %h want %h", got, r_data_u, eu);
        end
        n_vec++;
        if (r_last !== (got == ms - 1)) begin
          n_err++;
          $display("FAIL r_last[%0d]: got %b want %b", got, r_last, got == ms - 1);
        end
        if (r_ready) begin
          last_rs = r_data;
          last_ru = r_data_u;
          rvl = cyc;
          got++;
        end
      end
      @(posedge clk); #1; t++;
    end
    r_ready = 1'b1;
    if (got < ms) begin
      n_vec++; n_err++;
      $display("FAIL r_timeout: got %0d results want %0d", got, ms);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    bit seen = 1'b0;
    while (!seen && t < 20) begin
      @(negedge clk); seen = done;
      if (!seen) t++;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: done %b want 1 within 20 cycles", seen);
    end else begin
      n_vec++;
      if (busy !== 1'b0 || r_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_at_done: busy %b r_valid %b want 0 0", busy, r_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_batch(input int mc, input int ms, input bit ru,
                           input bit send_w, input bit rnd, input bit poke);
    int w0 = w_seen;
    pulse_start(mc, ru);
    fork
      produce(ms, send_w);
      consume(ms, rnd);
      if (poke) begin
        repeat (6) @(posedge clk);
        #1 start = 1'b1; m_count = 3;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
      end
    join
    wait_done();
    n_vec++;
    if (w_seen - w0 !== (send_w ? ROWS : 0)) begin
      n_err++;
      $display("FAIL w_ready_cycles: got %0d want %0d", w_seen - w0, send_w ? ROWS : 0);
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({r_valid, r_last, w_ready, a_ready, busy, done} !== 6'b0 || r_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b/%h want 0", {r_valid, r_last, w_ready, a_ready, busy, done}, r_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, w_ready, r_valid, done} !== 4'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b want 0000", {busy, w_ready, r_valid, done});
    end
  endtask

  task automatic test_identity();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) W[r][c] = (r == c) ? 8'd1 : 8'd0;
    avec = {32'h04030201};
    run_batch(1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (rv0 - hs0 !== 8) begin
      n_err++;
      $display("FAIL latency: got %0d want 8", rv0 - hs0);
    end
    n_vec++;
    if (last_rs !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      n_err++;
      $display("FAIL identity_data: got %h want 4,3,2,1", last_rs);
    end
  endtask

  task automatic test_signed();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) W[r][c] = 8'hFF;
    avec = {{8'd0, 8'd5, 8'h80, 8'd127}};
    run_batch(1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (last_rs !== {4{32'hFFFFFFFC}}) begin
      n_err++;
      $display("FAIL signed_sum: got %h want 4x fffffffc", last_rs);
    end
    n_vec++;
    if (last_ru !== {4{32'd66300}}) begin
      n_err++;
      $display("FAIL unsigned_sum: got %h want 4x %h", last_ru, 32'd66300);
    end
  endtask

  task automatic test_back_to_back();
    rand_w(); rand_a(16);
    run_batch(16, 16, 1'b0, 1'b1, 1'b1, 1'b1);
    rand_w(); rand_a(16);
    run_batch(16, 16, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (rvl - rv0 !== 15) begin
      n_err++;
      $display("FAIL throughput: span %0d want 15", rvl - rv0);
    end
  endtask

  task automatic test_zero_m();
    int w0 = w_seen;
    pulse_start(0, 1'b0);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_m_done: done %b busy %b want 1 0", done, busy);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_m_pulse: done %b busy %b want 0 0", done, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (w_seen !== w0) begin
      n_err++;
      $display("FAIL zero_m_w_ready: saw %0d cycles want 0", w_seen - w0);
    end
  endtask

  task automatic test_reset_mid();
    rand_w(); rand_a(8);
    pulse_start(8, 1'b0);
    produce(3, 1'b1);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({r_valid, r_last, w_ready, a_ready, busy, done} !== 6'b0 || r_data !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %b/%h want 0", {r_valid, r_last, w_ready, a_ready, busy, done}, r_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rand_w(); rand_a(5);
    run_batch(5, 5, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_clamp();
    rand_w(); rand_a(MAX_M);
    run_batch(300, MAX_M, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

`ifdef SA_WEIGHT_REUSE_EN
  task automatic test_reuse();
    rand_w(); rand_a(4);
    run_batch(4, 4, 1'b0, 1'b1, 1'b1, 1'b0);
    run_batch(4, 4, 1'b1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_batch(4, 4, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    r_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_identity();
    test_signed();
    test_back_to_back();
    test_zero_m();
    test_reset_mid();
    test_clamp();
`ifdef SA_WEIGHT_REUSE_EN
    test_reuse();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
